// File: rtl/ifu_pc_fetch.sv
// Instruction-fetch stage: PC register, imem address and the IF/ID register, with one-shot jump redirect.
// Optional performance counters are enabled by defining IFU_PERF_CNT_EN.
`ifndef IFU_DATAWIDTH
`define IFU_DATAWIDTH 32
`endif

module ifu_pc_fetch #(
    parameter int unsigned            DATAWIDTH = `IFU_DATAWIDTH,
    parameter logic [DATAWIDTH-1:0]   RESET_PC  = '0,
    parameter logic [DATAWIDTH-1:0]   NOP_INSTR = DATAWIDTH'(32'h0000_0013)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pipe_valid,
    input  logic                 IDU_JAL_instr,
    input  logic                 IDU_JALR_instr,
    input  logic [DATAWIDTH-1:0] IDU_PC_add_imme,
    input  logic [DATAWIDTH-1:0] IDU_JALR_target,
    output logic [DATAWIDTH-1:0] imem_addr,
    input  logic [DATAWIDTH-1:0] imem_rdata,
    output logic [DATAWIDTH-1:0] IFU_PC,
    output logic [DATAWIDTH-1:0] IFU_instr,
    output logic                 IFU_valid
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]          IFU_stall_cnt,
    output logic [31:0]          IFU_redirect_cnt
`endif
);

    typedef enum logic {ST_RUN, ST_WAIT} state_t;

    state_t                 r_state;
    logic [DATAWIDTH-1:0]   r_pc;
    logic [DATAWIDTH-1:0]   r_ifid_pc;
    logic [DATAWIDTH-1:0]   r_ifid_instr;
    logic                   r_ifid_valid;

    logic                   w_jump_req;
    logic [DATAWIDTH-1:0]   w_target;
    logic [DATAWIDTH-1:0]   w_pc_inc;

    // JAL wins over JALR; JALR target has bit 0 forced low
    assign w_jump_req = IDU_JAL_instr | IDU_JALR_instr;
    assign w_target   = IDU_JAL_instr ? IDU_PC_add_imme
                                      : (IDU_JALR_target & ~DATAWIDTH'(1));
    assign w_pc_inc   = r_pc + DATAWIDTH'(4);

    // WAIT marks a redirect already taken while decode still holds the jump
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_pc         <= RESET_PC;
            r_ifid_pc    <= '0;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_jump_req) begin
                        r_pc <= w_target;
                        if (pipe_valid) begin
                            r_ifid_pc    <= r_pc;
                            r_ifid_instr <= NOP_INSTR;
                            r_ifid_valid <= 1'b0;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end else if (pipe_valid) begin
                        r_pc         <= w_pc_inc;
                        r_ifid_pc    <= r_pc;
                        r_ifid_instr <= imem_rdata;
                        r_ifid_valid <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (pipe_valid) begin
                        r_pc         <= w_pc_inc;
                        r_ifid_pc    <= r_pc;
                        r_ifid_instr <= imem_rdata;
                        r_ifid_valid <= 1'b1;
                        r_state      <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign imem_addr = r_pc;
    assign IFU_PC    = r_ifid_pc;
    assign IFU_instr = r_ifid_instr;
    assign IFU_valid = r_ifid_valid;

`ifdef IFU_PERF_CNT_EN
    logic        w_redirect;
    logic [31:0] r_stall_cnt;
    logic [31:0] r_redirect_cnt;

    assign w_redirect = (r_state == ST_RUN) && w_jump_req;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt    <= '0;
            r_redirect_cnt <= '0;
        end else begin
            if (!pipe_valid) r_stall_cnt    <= r_stall_cnt + 32'd1;
            if (w_redirect)  r_redirect_cnt <= r_redirect_cnt + 32'd1;
        end
    end

    assign IFU_stall_cnt    = r_stall_cnt;
    assign IFU_redirect_cnt = r_redirect_cnt;
`endif

endmodule

// File: tb/tb_ifu_pc_fetch.sv
// Self-checking bench for ifu_pc_fetch: directed vector table, hand sequences, and random run vs. a reference model.
// Counter checks are compiled in when IFU_PERF_CNT_EN is defined.
module tb_ifu_pc_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_valid;
    logic        jal, jalr;
    logic [31:0] imm, jtgt;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] ifu_pc, ifu_instr;
    logic        ifu_valid;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] stall_cnt, redirect_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
    endfunction

    assign imem_rdata = mem_f(imem_addr);

    ifu_pc_fetch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pipe_valid      (pipe_valid),
        .IDU_JAL_instr   (jal),
        .IDU_JALR_instr  (jalr),
        .IDU_PC_add_imme (imm),
        .IDU_JALR_target (jtgt),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .IFU_PC          (ifu_pc),
        .IFU_instr       (ifu_instr),
        .IFU_valid       (ifu_valid)
`ifdef IFU_PERF_CNT_EN
        ,
        .IFU_stall_cnt   (stall_cnt),
        .IFU_redirect_cnt(redirect_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, let the edge happen, then settle away from it
    task automatic step(input logic r, input logic pv, input logic j, input logic jr,
                        input logic [31:0] im, input logic [31:0] jt);
        rst_n = r; pipe_valid = pv; jal = j; jalr = jr; imm = im; jtgt = jt;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        r, pv, j, jr;
        logic [31:0] im, jt;
        logic [31:0] e_addr, e_ifpc;
        logic        e_valid;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic pv, input logic j, input logic jr,
                                input logic [31:0] im, input logic [31:0] jt,
                                input logic [31:0] ea, input logic [31:0] ep, input logic ev);
        vec_t v;
        v.r = r; v.pv = pv; v.j = j; v.jr = jr; v.im = im; v.jt = jt;
        v.e_addr = ea; v.e_ifpc = ep; v.e_valid = ev;
        return v;
    endfunction

    localparam int NV = 27;
    vec_t vecs [NV];

    // Reference model state
    logic [31:0] m_pc, m_ifpc, m_instr;
    logic        m_valid, m_jump_taken;
    logic [31:0] m_stall, m_redir;

    task automatic model(input logic r, input logic pv, input logic j, input logic jr,
                         input logic [31:0] im, input logic [31:0] jt);
        logic [31:0] tgt;
        if (!r) begin
            m_pc = 32'h0; m_ifpc = 32'h0; m_instr = NOP; m_valid = 1'b0;
            m_jump_taken = 1'b0; m_stall = 0; m_redir = 0;
            return;
        end
        tgt = j ? im : {jt[31:1], 1'b0};
        if (!pv) m_stall++;
        if (m_jump_taken) begin
            if (pv) begin
                m_ifpc = m_pc; m_instr = mem_f(m_pc); m_valid = 1'b1;
                m_pc = m_pc + 32'd4; m_jump_taken = 1'b0;
            end
        end else if (j || jr) begin
            m_redir++;
            if (pv) begin
                m_ifpc = m_pc; m_instr = NOP; m_valid = 1'b0;
            end else begin
                m_jump_taken = 1'b1;
            end
            m_pc = tgt;
        end else if (pv) begin
            m_ifpc = m_pc; m_instr = mem_f(m_pc); m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
        end
    endtask

    initial begin
        rst_n = 1'b0; pipe_valid = 1'b0; jal = 1'b0; jalr = 1'b0; imm = '0; jtgt = '0;

        vecs[0]  = mk(0,1,0,0, 0,0,              32'h000, 32'h000, 0);
        vecs[1]  = mk(0,1,0,0, 0,0,              32'h000, 32'h000, 0);
        vecs[2]  = mk(1,1,0,0, 0,0,              32'h004, 32'h000, 1);
        vecs[3]  = mk(1,1,0,0, 0,0,              32'h008, 32'h004, 1);
        vecs[4]  = mk(1,1,0,0, 0,0,              32'h00C, 32'h008, 1);
        vecs[5]  = mk(1,1,0,0, 0,0,              32'h010, 32'h00C, 1);
        vecs[6]  = mk(1,0,1,0, 32'h100,0,        32'h100, 32'h00C, 1);
        vecs[7]  = mk(1,1,1,0, 32'h100,0,        32'h104, 32'h100, 1);
        vecs[8]  = mk(1,1,0,0, 0,0,              32'h108, 32'h104, 1);
        vecs[9]  = mk(1,0,0,1, 0,32'h203,        32'h202, 32'h104, 1);
        vecs[10] = mk(1,0,0,1, 0,32'h303,        32'h202, 32'h104, 1);
        vecs[11] = mk(1,1,0,1, 0,32'h303,        32'h206, 32'h202, 1);
        vecs[12] = mk(1,1,0,0, 0,0,              32'h20A, 32'h206, 1);
        vecs[13] = mk(1,1,1,0, 32'h40,0,         32'h040, 32'h20A, 0);
        vecs[14] = mk(1,1,0,0, 0,0,              32'h044, 32'h040, 1);
        vecs[15] = mk(1,0,0,0, 0,0,              32'h044, 32'h040, 1);
        vecs[16] = mk(1,0,0,0, 0,0,              32'h044, 32'h040, 1);
        vecs[17] = mk(1,0,0,0, 0,0,              32'h044, 32'h040, 1);
        vecs[18] = mk(1,1,0,0, 0,0,              32'h048, 32'h044, 1);
        vecs[19] = mk(1,1,1,1, 32'h80,32'h555,   32'h080, 32'h048, 0);
        vecs[20] = mk(1,1,0,0, 0,0,              32'h084, 32'h080, 1);
        vecs[21] = mk(1,0,0,1, 0,32'h301,        32'h300, 32'h080, 1);
        vecs[22] = mk(0,0,0,1, 0,32'h301,        32'h000, 32'h000, 0);
        vecs[23] = mk(1,1,0,1, 0,32'h301,        32'h300, 32'h000, 0);
        vecs[24] = mk(1,1,0,0, 0,0,              32'h304, 32'h300, 1);
        vecs[25] = mk(1,1,1,0, 32'hFFFF_FFFC,0,  32'hFFFF_FFFC, 32'h304, 0);
        vecs[26] = mk(1,1,0,0, 0,0,              32'h000, 32'hFFFF_FFFC, 1);

        #2;
        for (int i = 0; i < NV; i++) begin
            step(vecs[i].r, vecs[i].pv, vecs[i].j, vecs[i].jr, vecs[i].im, vecs[i].jt);
            check($sformatf("vec%0d_addr", i),  imem_addr, vecs[i].e_addr);
            check($sformatf("vec%0d_ifpc", i),  ifu_pc,    vecs[i].e_ifpc);
            check($sformatf("vec%0d_valid", i), 32'(ifu_valid), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d_instr", i), ifu_instr,
                  vecs[i].e_valid ? mem_f(vecs[i].e_ifpc) : NOP);
        end

        // Long WAIT with a changing JAL target must not redirect again
        step(0,1,0,0,0,0);
        step(1,1,0,0,0,0);
        step(1,0,1,0,32'h500,0);
        for (int k = 0; k < 4; k++) step(1,0,1,0,32'h600 + 32'(k),0);
        check("longwait_addr", imem_addr, 32'h500);
        check("longwait_ifpc", ifu_pc, 32'h0);
        step(1,1,1,0,32'h700,0);
        check("longwait_release_ifpc", ifu_pc, 32'h500);
        check("longwait_release_addr", imem_addr, 32'h504);

`ifdef IFU_PERF_CNT_EN
        step(0,1,0,0,0,0);
        check("cnt_reset_stall", stall_cnt, 32'd0);
        for (int k = 0; k < 3; k++) step(1,0,0,0,0,0);
        check("cnt_stall3", stall_cnt, 32'd3);
        check("cnt_redir0", redirect_cnt, 32'd0);
        step(1,0,1,0,32'h40,0);
        step(1,0,1,0,32'h40,0);
        check("cnt_redir_once", redirect_cnt, 32'd1);
        check("cnt_stall5", stall_cnt, 32'd5);
        step(0,0,1,0,32'h40,0);
        check("cnt_midwait_stall", stall_cnt, 32'd0);
        check("cnt_midwait_redir", redirect_cnt, 32'd0);
        check("midwait_addr", imem_addr, 32'h0);
`endif

        // Random run against the reference model
        model(0,0,0,0,0,0);
        step(0,0,0,0,0,0);
        for (int c = 0; c < 600; c++) begin
            logic r, pv, j, jr;
            logic [31:0] im, jt;
            r  = ($urandom_range(99) != 0);
            pv = ($urandom_range(9) < 7);
            j  = ($urandom_range(9) == 0);
            jr = ($urandom_range(9) == 0);
            im = $urandom;
            jt = $urandom;
            model(r, pv, j, jr, im, jt);
            step(r, pv, j, jr, im, jt);
            check("rnd_addr",  imem_addr, m_pc);
            check("rnd_ifpc",  ifu_pc,    m_ifpc);
            check("rnd_instr", ifu_instr, m_instr);
            check("rnd_valid", 32'(ifu_valid), 32'(m_valid));
`ifdef IFU_PERF_CNT_EN
            check("rnd_stall_cnt", stall_cnt, m_stall);
            check("rnd_redir_cnt", redirect_cnt, m_redir);
`endif
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
